rr_mux_arb: RTL and testbench



---
 rtl/rr_mux_arb.sv | 100 ++++++++++
 tb/tb_rr_mux_arb.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: registered N_CH:1 multiplexer with round-robin arbitration and
// valid/ready handshakes on every input channel and on the single output.
// Optional static-select mode is compiled in with `define RR_MUX_FORCE_SEL_EN,
// which adds the force_en/force_sel ports.
module rr_mux_arb #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_valid,
  output logic [N_CH-1:0]          in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
`ifdef RR_MUX_FORCE_SEL_EN
  input  logic                     force_en,
  input  logic [SEL_W-1:0]         force_sel,
`endif
  input  logic                     out_ready
);

  logic [SEL_W-1:0]  ptr;
  logic [N_CH-1:0]   elig;
  logic [DATA_W-1:0] ch_data [N_CH];
  logic              load;
  logic              gnt_found;
  logic [SEL_W-1:0]  gnt_idx;
  logic [SEL_W-1:0]  ptr_nxt;
  logic [SEL_W-1:0]  scan_idx;
  int unsigned       scan_pos;

  // Output register is free, or its word is being consumed this cycle.
  assign load = ~out_valid | out_ready;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign ch_data[i] = in_data[i*DATA_W +: DATA_W];
`ifdef RR_MUX_FORCE_SEL_EN
    // A forced select outside 0..N_CH-1 matches no channel, so nothing is granted.
    assign elig[i] = in_valid[i] & (~force_en | (force_sel == SEL_W'(i)));
`else
    assign elig[i] = in_valid[i];
`endif
  end

  // Round-robin scan starting at ptr; first eligible channel wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      scan_pos = (32'(ptr) + k) % N_CH;
      scan_idx = SEL_W'(scan_pos);
      if (!gnt_found && elig[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  // Pointer moves to the channel after the winner, wrapping at N_CH.
  always_comb begin
    ptr_nxt = SEL_W'((32'(gnt_idx) + 1) % N_CH);
  end

  // One-hot accept for the granted channel; held low while in reset.
  always_comb begin
    in_ready = '0;
    if (rst_n && load && gnt_found)
      in_ready[gnt_idx] = 1'b1;
  end

  // Output register and priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (load) begin
      if (gnt_found) begin
        out_data  <= ch_data[gnt_idx];
        out_sel   <= gnt_idx;
        out_valid <= 1'b1;
`ifdef RR_MUX_FORCE_SEL_EN
        if (!force_en)
          ptr <= ptr_nxt;
`else
        ptr <= ptr_nxt;
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: vector table, hand-written reset sequences and a randomized
// phase compared against a behavioural round-robin model (4 channels, 8 bits).
module tb_rr_mux_arb;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_mux_arb #(.N_CH(N), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  v;
    logic        r;
    logic [31:0] d;
    logic [3:0]  rdy;
    logic [1:0]  sel;
    logic        ov;
    logic [7:0]  od;
  } vec_t;

  vec_t tbl [15];

  // Behavioural model state
  int          m_ptr;
  logic        m_valid;
  logic [7:0]  m_data;
  int          m_sel;

  initial begin
    logic [31:0] dflt;
    int          g;
    logic        ld;
    logic [3:0]  exp_rdy;

    dflt = 32'h13121110;
    //          v        r     d             rdy      sel ov od
    tbl[0]  = '{4'b1111, 1'b1, dflt,         4'b0001, 2'd0, 1'b1, 8'h10};
    tbl[1]  = '{4'b1111, 1'b1, dflt,         4'b0010, 2'd1, 1'b1, 8'h11};
    tbl[2]  = '{4'b1111, 1'b1, dflt,         4'b0100, 2'd2, 1'b1, 8'h12};
    tbl[3]  = '{4'b1111, 1'b1, dflt,         4'b1000, 2'd3, 1'b1, 8'h13};
    tbl[4]  = '{4'b1111, 1'b1, dflt,         4'b0001, 2'd0, 1'b1, 8'h10};
    tbl[5]  = '{4'b0010, 1'b1, dflt,         4'b0010, 2'd1, 1'b1, 8'h11};
    tbl[6]  = '{4'b1010, 1'b1, dflt,         4'b1000, 2'd3, 1'b1, 8'h13};
    tbl[7]  = '{4'b1010, 1'b1, dflt,         4'b0010, 2'd1, 1'b1, 8'h11};
    tbl[8]  = '{4'b0000, 1'b1, dflt,         4'b0000, 2'd1, 1'b0, 8'h11};
    tbl[9]  = '{4'b0000, 1'b0, dflt,         4'b0000, 2'd1, 1'b0, 8'h11};
    tbl[10] = '{4'b0100, 1'b0, 32'h13A51110, 4'b0100, 2'd2, 1'b1, 8'hA5};
    tbl[11] = '{4'b1111, 1'b0, dflt,         4'b0000, 2'd2, 1'b1, 8'hA5};
    tbl[12] = '{4'b1111, 1'b0, dflt,         4'b0000, 2'd2, 1'b1, 8'hA5};
    tbl[13] = '{4'b1111, 1'b0, dflt,         4'b0000, 2'd2, 1'b1, 8'hA5};
    tbl[14] = '{4'b1111, 1'b1, dflt,         4'b1000, 2'd3, 1'b1, 8'h13};

    // Reset with every channel requesting
    rst_n = 1'b0; in_valid = 4'b1111; in_data = dflt; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_sel",   32'(out_sel),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table, one cycle per entry
    for (int i = 0; i < 15; i++) begin
      in_valid = tbl[i].v; out_ready = tbl[i].r; in_data = tbl[i].d;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_out_sel", i),   32'(out_sel),   32'(tbl[i].sel));
      chk($sformatf("tbl%0d_out_data", i),  32'(out_data),  32'(tbl[i].od));
      @(negedge clk);
    end

    // Reset while a word is held: clears without a clock edge
    in_valid = 4'b1111; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data",  32'(out_data),  32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; in_data = 32'h44332211;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'b0001);
    @(posedge clk); #1;
    chk("rel_out_sel",  32'(out_sel),  32'd0);
    chk("rel_out_data", 32'(out_data), 32'h11);
    m_ptr = 1; m_valid = 1'b1; m_data = 8'h11; m_sel = 0;
    @(negedge clk);

    // Randomized traffic against the model
    for (int it = 0; it < 300; it++) begin
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      ld = !m_valid || out_ready;
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_rdy = (ld && g >= 0) ? 4'(1 << g) : 4'b0000;
      #1;
      chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
      if (ld) begin
        if (g >= 0) begin
          m_valid = 1'b1;
          m_sel   = g;
          m_data  = in_data[g*8 +: 8];
          m_ptr   = (g + 1) % N;
        end else begin
          m_valid = 1'b0;
        end
      end
      @(posedge clk); #1;
      chk("rnd_out_valid", 32'(out_valid), 32'(m_valid));
      chk("rnd_out_sel",   32'(out_sel),   32'(m_sel));
      chk("rnd_out_data",  32'(out_data),  32'(m_data));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
